// File: rtl/parameter_pkg.sv
// Shared widths, tag constants and per-entry state for the reservation-station issue logic.
package parameter_pkg;

   localparam int PHYS_REG_W = 7;
   localparam logic [PHYS_REG_W-1:0] PHY_ZERO = '0;

   typedef enum logic [1:0] {
      RS_ALU = 2'd0,
      RS_LSU = 2'd1,
      RS_BRU = 2'd2
   } rs_type_e;

   typedef struct packed {
      logic                  valid;
      logic                  in_flight;
      logic                  s1_rdy;
      logic                  s2_rdy;
      logic [PHYS_REG_W-1:0] s1_tag;
      logic [PHYS_REG_W-1:0] s2_tag;
   } rs_entry_state_t;

   // PHY_ZERO is always dispatched ready, so a broadcast of it never counts as a wakeup.
   function automatic logic wb_hit(input logic [PHYS_REG_W-1:0] tag,
                                   input logic                  v0,
                                   input logic [PHYS_REG_W-1:0] t0,
                                   input logic                  v1,
                                   input logic [PHYS_REG_W-1:0] t1);
      return (tag != PHY_ZERO) && ((v0 && (tag == t0)) || (v1 && (tag == t1)));
   endfunction

endpackage

// File: rtl/rs_issue_select_if.sv
// Dispatch, writeback and issue signals between a reservation station and its issue selector.
// Handshake: the selection transfers on a cycle where issue_valid && issue_ready; issue_valid and issue_idx hold while stalled.
interface rs_issue_select_if #(parameter int NUM_RS_ENTRIES = 8);
   import parameter_pkg::*;

   localparam int IDX_W = $clog2(NUM_RS_ENTRIES);

   logic                  alloc_valid_0;
   logic                  alloc_valid_1;
   logic [IDX_W-1:0]      alloc_idx_0;
   logic [IDX_W-1:0]      alloc_idx_1;
   logic [PHYS_REG_W-1:0] alloc_src1_tag_0;
   logic [PHYS_REG_W-1:0] alloc_src2_tag_0;
   logic [PHYS_REG_W-1:0] alloc_src1_tag_1;
   logic [PHYS_REG_W-1:0] alloc_src2_tag_1;
   logic                  alloc_src1_rdy_0;
   logic                  alloc_src2_rdy_0;
   logic                  alloc_src1_rdy_1;
   logic                  alloc_src2_rdy_1;
   logic                  wb_valid_0;
   logic                  wb_valid_1;
   logic [PHYS_REG_W-1:0] wb_tag_0;
   logic [PHYS_REG_W-1:0] wb_tag_1;
   logic                  issue_valid;
   logic                  issue_ready;
   logic [IDX_W-1:0]      issue_idx;
   logic                  issue_free_valid;
   logic [IDX_W:0]        issue_free;
   logic [IDX_W:0]        num_occupied;

   modport master (
      output alloc_valid_0, alloc_valid_1, alloc_idx_0, alloc_idx_1,
             alloc_src1_tag_0, alloc_src2_tag_0, alloc_src1_tag_1, alloc_src2_tag_1,
             alloc_src1_rdy_0, alloc_src2_rdy_0, alloc_src1_rdy_1, alloc_src2_rdy_1,
             wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1, issue_ready,
      input  issue_valid, issue_idx, issue_free_valid, issue_free, num_occupied
   );

   modport slave (
      input  alloc_valid_0, alloc_valid_1, alloc_idx_0, alloc_idx_1,
             alloc_src1_tag_0, alloc_src2_tag_0, alloc_src1_tag_1, alloc_src2_tag_1,
             alloc_src1_rdy_0, alloc_src2_rdy_0, alloc_src1_rdy_1, alloc_src2_rdy_1,
             wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1, issue_ready,
      output issue_valid, issue_idx, issue_free_valid, issue_free, num_occupied
   );

endinterface

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: grants the candidate that has no older candidate.
module rs_age_select #(
   parameter int N = 8
) (
   input  logic [N-1:0]         cand,
   input  logic [N-1:0][N-1:0]  older,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 grant_any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = cand[i] && ((older[i] & cand) == '0);
      end
      // The age matrix is a strict order over valid entries, so grant is one-hot.
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_idx = grant_idx | $clog2(N)'(i);
      end
      grant_any = |grant;
   end

endmodule

// File: rtl/rs_issue_select.sv
// Issue scheduler for one reservation station: wakeup, oldest-ready select, issue register
// and slot release back to the free-slot allocator.
module rs_issue_select
   import parameter_pkg::*;
#(
   parameter int NUM_RS_ENTRIES = 8,
   parameter int TYPE           = 0
) (
   input logic         clk,
   input logic         rst,
   input logic         flush,
   rs_issue_select_if.slave bus
);

   localparam int N     = NUM_RS_ENTRIES;
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = IDX_W + 1;

   if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
      $error("rs_issue_select: NUM_RS_ENTRIES must be a power of two >= 2");
   end
   if ((TYPE != int'(RS_ALU)) && (TYPE != int'(RS_LSU)) && (TYPE != int'(RS_BRU))) begin : g_bad_type
      $error("rs_issue_select: unknown TYPE");
   end

   rs_entry_state_t        ent_q [N];
   rs_entry_state_t        ent_d [N];
   logic [N-1:0][N-1:0]    older_q, older_d;
   logic                   issue_valid_q, issue_valid_d;
   logic [IDX_W-1:0]       issue_idx_q, issue_idx_d;

   logic [N-1:0]           valid_mask, cand, grant, oh0, oh1;
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_any, fire, load_en, alloc_conflict;

   function automatic logic hit(input logic [PHYS_REG_W-1:0] tag);
      return wb_hit(tag, bus.wb_valid_0, bus.wb_tag_0, bus.wb_valid_1, bus.wb_tag_1);
   endfunction

   always_comb begin
      valid_mask = '0;
      cand       = '0;
      for (int i = 0; i < N; i++) begin
         valid_mask[i] = ent_q[i].valid;
         cand[i]       = ent_q[i].valid && !ent_q[i].in_flight && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
      end
   end

   rs_age_select #(.N(N)) u_age_select (
      .cand      (cand),
      .older     (older_q),
      .grant     (grant),
      .grant_idx (sel_idx),
      .grant_any (sel_any)
   );

   assign fire    = issue_valid_q && bus.issue_ready && !flush;
   assign load_en = !issue_valid_q || fire;
   assign oh0     = {{(N-1){1'b0}}, 1'b1} << bus.alloc_idx_0;
   assign oh1     = {{(N-1){1'b0}}, 1'b1} << bus.alloc_idx_1;

   always_comb begin
      ent_d   = ent_q;
      older_d = older_q;
      if (flush) begin
         for (int i = 0; i < N; i++) begin
            ent_d[i].valid     = 1'b0;
            ent_d[i].in_flight = 1'b0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (ent_q[i].valid && hit(ent_q[i].s1_tag)) ent_d[i].s1_rdy = 1'b1;
            if (ent_q[i].valid && hit(ent_q[i].s2_tag)) ent_d[i].s2_rdy = 1'b1;
            if (load_en && grant[i]) ent_d[i].in_flight = 1'b1;
         end
         if (fire) begin
            ent_d[issue_idx_q].valid     = 1'b0;
            ent_d[issue_idx_q].in_flight = 1'b0;
         end
         if (bus.alloc_valid_0) begin
            ent_d[bus.alloc_idx_0] = '{valid: 1'b1, in_flight: 1'b0,
                                       s1_rdy: bus.alloc_src1_rdy_0 | hit(bus.alloc_src1_tag_0),
                                       s2_rdy: bus.alloc_src2_rdy_0 | hit(bus.alloc_src2_tag_0),
                                       s1_tag: bus.alloc_src1_tag_0, s2_tag: bus.alloc_src2_tag_0};
            for (int r = 0; r < N; r++) older_d[r][bus.alloc_idx_0] = 1'b0;
         end
         if (bus.alloc_valid_1) begin
            ent_d[bus.alloc_idx_1] = '{valid: 1'b1, in_flight: 1'b0,
                                       s1_rdy: bus.alloc_src1_rdy_1 | hit(bus.alloc_src1_tag_1),
                                       s2_rdy: bus.alloc_src2_rdy_1 | hit(bus.alloc_src2_tag_1),
                                       s1_tag: bus.alloc_src1_tag_1, s2_tag: bus.alloc_src2_tag_1};
            for (int r = 0; r < N; r++) older_d[r][bus.alloc_idx_1] = 1'b0;
         end
         // Rows are written after the column clears so a dual alloc orders slot 0 before slot 1.
         if (bus.alloc_valid_0) older_d[bus.alloc_idx_0] = valid_mask & ~oh0;
         if (bus.alloc_valid_1)
            older_d[bus.alloc_idx_1] = (valid_mask | (bus.alloc_valid_0 ? oh0 : '0)) & ~oh1;
      end
   end

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_idx_d   = issue_idx_q;
      if (flush) begin
         issue_valid_d = 1'b0;
         issue_idx_d   = '0;
      end else if (load_en) begin
         issue_valid_d = sel_any;
         if (sel_any) issue_idx_d = sel_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ent_q[i] <= '0;
         older_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_idx_q   <= '0;
      end else begin
         ent_q         <= ent_d;
         older_q       <= older_d;
         issue_valid_q <= issue_valid_d;
         issue_idx_q   <= issue_idx_d;
      end
   end

   assign bus.issue_valid      = issue_valid_q;
   assign bus.issue_idx        = issue_idx_q;
   assign bus.issue_free_valid = fire;
   assign bus.issue_free       = {1'b0, issue_idx_q};
   assign bus.num_occupied     = CNT_W'($countones(valid_mask));

   always_comb begin
      alloc_conflict = !flush &&
                       ((bus.alloc_valid_0 && ent_q[bus.alloc_idx_0].valid) ||
                        (bus.alloc_valid_1 && ent_q[bus.alloc_idx_1].valid) ||
                        (bus.alloc_valid_0 && bus.alloc_valid_1 && (bus.alloc_idx_0 == bus.alloc_idx_1)));
   end

   a_no_alloc_into_valid: assert property (@(posedge clk) disable iff (rst) !alloc_conflict)
      else $error("rs_issue_select: allocation into an occupied slot");

endmodule

// File: doc/rs_issue_select.md
# rs_issue_select

Issue-side scheduler for one reservation station: tracks which RS slots hold dispatched micro-ops, wakes source operands on writeback broadcasts, selects the oldest fully ready entry each cycle, and presents it to its functional unit through a valid/ready handshake. When an issue fires, the slot index is returned to the station's free-slot allocator on `issue_free_valid`/`issue_free`, closing the allocate/release loop. One instance sits beside each RS (ALU, LSU, BRU), selected by `TYPE`.

## Interface
- `NUM_RS_ENTRIES`, 8: slots in the station; power of two, ≥ 2.
- `TYPE`, 0: station kind (0 ALU, 1 LOAD/STORE, 2 BRANCH); informational, no behavioural effect.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous squash of all entries.
- `alloc_valid_0`, `alloc_valid_1` in 1 each: dispatch writes into slot 0/1 this cycle; slot 0 is older.
- `alloc_idx_0`, `alloc_idx_1` in $clog2(N) each: slot indices granted by the free-slot allocator.
- `alloc_src1_tag_k`, `alloc_src2_tag_k` in PHYS_REG_W (k = 0,1): physical source tags.
- `alloc_src1_rdy_k`, `alloc_src2_rdy_k` in 1 (k = 0,1): operand already available at dispatch.
- `wb_valid_0`, `wb_valid_1` in 1: writeback broadcast ports.
- `wb_tag_0`, `wb_tag_1` in PHYS_REG_W: broadcast destination tags.
- `issue_valid` out 1: registered selection available.
- `issue_ready` in 1: FU accepts the selection.
- `issue_idx` out $clog2(N): slot being issued, used to read the RS payload.
- `issue_free_valid` out 1: slot released this cycle.
- `issue_free` out $clog2(N)+1: released slot index, MSB always 0.
- `num_occupied` out $clog2(N)+1: count of valid entries.

## Operation
- Per-entry state: `valid`, `in_flight`, `s1_rdy`, `s2_rdy`, `s1_tag`, `s2_tag`; N×N age matrix with `older[i][j]` = 1 when entry j was allocated before entry i.
- Allocation: sets `valid`. Ready bits are loaded as alloc_rdy OR'd with a same-cycle wakeup match. The new row of `older` is the current valid mask, and the column for the new entry is cleared in all other rows. On dual allocation, entry 1's row also includes entry 0.
- Wakeup: a valid entry whose tag equals any valid `wb_tag` sets the matching ready bit. Tag 0 (PHY_ZERO) never needs wakeup; it is dispatched ready.
- Candidate = `valid` & !`in_flight` & `s1_rdy` & `s2_rdy`. The selected entry is the candidate with no older candidate.
- Issue register: loads the selected candidate when it is empty or firing (`issue_valid && issue_ready`). On load, the entry's `in_flight` is set. While stalled, it holds `issue_idx` stable.
- Fire: clears the entry's `valid` and `in_flight`, pulses `issue_free_valid` with `issue_free = {1'b0, issue_idx}` in the same cycle.
- Flush: clears all `valid`, `in_flight`, and the issue register. No `issue_free` pulse is produced, because the allocator rebuilds its own list on flush. `flush` overrides alloc, wakeup, and fire in the same cycle.
- Allocating into a slot that is already valid is illegal and caught by an assertion.

## Timing
- Reset values: `issue_valid` 0, `issue_idx` 0, `issue_free_valid` 0, `issue_free` 0, `num_occupied` 0, all entries invalid, age matrix 0.
- Allocation at cycle t makes the entry selectable at t+1, and it can appear on `issue_valid` at t+2 at the earliest.
- Wakeup at t (including a same-cycle alloc bypass) makes the entry selectable at t+1.
- Back-to-back: when the issue register fires at t, a new selection loads at the same edge, so `issue_valid` stays high at t+1 with no bubble.
- `issue_free_valid` is combinational from the fire condition: one pulse per fire, at most one per cycle.
- Full station (all valid) with no candidate: `issue_valid` stays 0 and there is no deadlock; the next wakeup resumes issue.
- If `rst` asserts mid-stall, all state clears asynchronously and `issue_valid` drops immediately.

## Structure
- `parameter_pkg` provides `PHYS_REG_W`, the PHY_ZERO constant, and the RS type encodings (ALU/LSU/BRU). It adds a packed `rs_entry_state_t` struct for the per-entry bits.
- One sub-module, `rs_age_select`: combinational oldest-ready picker that takes the candidate vector and age matrix and returns a one-hot grant plus an index.

## Test plan
- Reset, then dispatch slot 3 with both sources ready at t0 -> `issue_valid` = 1, `issue_idx` = 3 at t2; `issue_ready` = 1 at t2 -> `issue_free_valid` = 1, `issue_free` = 3 at t2, `num_occupied` 1→0.
- Dispatch slot 5 (older) then slot 2, both ready -> issue order 5, then 2, on consecutive cycles with `issue_ready` held at 1.
- Slot 1 waits on tag 17, `wb_valid_0` = 1 with `wb_tag_0` = 17 at t5 -> `issue_valid` with idx 1 at t7. Also check the bypass case: alloc and wakeup in the same cycle behaves like alloc with ready = 1.
- `issue_ready` = 0 for 4 cycles with 3 ready entries -> `issue_idx` stable, no `issue_free` pulse. On release, all 3 entries issue in age order, one per cycle.
- Fill all 8 slots, then `flush` -> `num_occupied` = 0 and `issue_valid` = 0 next cycle, with no `issue_free_valid` pulse.
- Assert `rst` mid-stall with `issue_valid` = 1 -> outputs return to reset values asynchronously.
